// File: rtl/matrix_reader_pkg.sv
// Shared definitions for the matrix operand loader: FSM encoding and default word width.
package matrix_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WORD_WIDTH = 32;

endpackage

// File: rtl/matrix_reader_if.sv
// Stream-in handshake, control and index-addressed read port of the matrix loader.
interface matrix_reader_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 8,
    parameter int WIDTH = 32,
    parameter int ROW_W = $clog2(ROWS),
    parameter int COL_W = $clog2(COLS)
);
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic             in_stb;
    logic             in_ack;
    logic [ROW_W-1:0] rd_i;
    logic [COL_W-1:0] rd_j;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;

    // Producer / consumer side
    modport master (
        output start, in_data, in_stb, rd_i, rd_j,
        input  in_ack, rd_data, busy, done
    );

    // Loader side
    modport slave (
        input  start, in_data, in_stb, rd_i, rd_j,
        output in_ack, rd_data, busy, done
    );
endinterface

// File: rtl/matrix_reader_index_counter.sv
// Row-major (i, j) write-index counter; wraps j at COLS-1 and holds at the last element.
module matrix_index_counter #(
    parameter int ROWS  = 4,
    parameter int COLS  = 8,
    parameter int ROW_W = $clog2(ROWS),
    parameter int COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ROW_W-1:0] i,
    output logic [COL_W-1:0] j,
    output logic             last
);

    logic [ROW_W-1:0] r_i;
    logic [COL_W-1:0] r_j;
    logic             w_j_end;

    assign w_j_end = (r_j == COL_W'(COLS - 1));
    assign last    = (r_i == ROW_W'(ROWS - 1)) && w_j_end;
    assign i       = r_i;
    assign j       = r_j;

    // Compare-based wrap: the counters never rely on natural overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i <= '0;
            r_j <= '0;
        end else if (clr) begin
            r_i <= '0;
            r_j <= '0;
        end else if (inc && !last) begin
            if (w_j_end) begin
                r_j <= '0;
                r_i <= r_i + ROW_W'(1);
            end else begin
                r_j <= r_j + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_reader.sv
// Loads a ROWS x COLS matrix streamed row-major over a strobe/ack handshake and
// serves it through a combinational index-addressed read port.
module matrix_reader
    import matrix_reader_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 8,
    parameter int WIDTH = WORD_WIDTH,
    parameter int ROW_W = $clog2(ROWS),
    parameter int COL_W = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            rst,
    matrix_reader_if.slave  bus
);

    state_t           r_state;
    state_t           w_next;
    logic             r_in_ack;
    logic             w_clr;
    logic             w_inc;
    logic             w_we;
    logic             w_last;
    logic [ROW_W-1:0] w_i;
    logic [COL_W-1:0] w_j;

    logic [WIDTH-1:0] r_mem [ROWS][COLS];

    matrix_index_counter #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .inc  (w_inc),
        .i    (w_i),
        .j    (w_j),
        .last (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_in_ack <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_in_ack <= w_we;
        end
    end

    // ACK ignores in_stb so the producer has a cycle to drop or replace its word
    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_inc  = 1'b0;
        w_we   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = LOAD;
                    w_clr  = 1'b1;
                end
            end
            LOAD: begin
                if (bus.in_stb) begin
                    w_we   = 1'b1;
                    w_next = ACK;
                end
            end
            ACK: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_inc  = 1'b1;
                    w_next = LOAD;
                end
            end
            DONE: begin
                if (bus.start) begin
                    w_next = LOAD;
                    w_clr  = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Buffer holds data only; it is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_i][w_j] <= bus.in_data;
        end
    end

    assign bus.rd_data = r_mem[bus.rd_i][bus.rd_j];
    assign bus.in_ack  = r_in_ack;
    assign bus.busy    = (r_state == LOAD) || (r_state == ACK);
    assign bus.done    = (r_state == DONE);

endmodule
